uart_mem_dumper: RTL and testbench

UART readback engine: on a `start` pulse it reads `word_count` consecutive 32-bit words from the instruction memory, beginning at word address 0. It transmits each word over a single TX line as four 8N1 bytes, least significant byte first. It is the transmit-side counterpart of the UART loader, and uses the same baud arithmetic and the same word-addressed layout, so the host can verify a loaded program byte-for-byte.

---
 rtl/uart_mem_dumper.sv | 161 ++++++++++++++++
 tb/tb_uart_mem_dumper.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mem_dumper.sv
// uart_mem_dumper: reads word_count words from address 0 and sends each as four 8N1 bytes, LSB first.
// Define UART_DUMP_CHECKSUM_EN to append one frame carrying the XOR of every data byte sent.
module uart_mem_dumper #(
   parameter int CLK_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] word_count,
   output logic [31:0] rd_addr,
   output logic        rd_en,
   input  logic [31:0] rd_data,
   output logic        tx,
   output logic        busy,
   output logic        done
);
   localparam int CLK_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int CW = $clog2(CLK_PER_BIT);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`ifdef UART_DUMP_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, CHKSUM, FINISH} state_t;
   logic [7:0] checksum;
`else
   typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, FINISH} state_t;
`endif

   state_t        state;
   tx_state_t     tx_state;
   logic [CW-1:0] bit_cnt;
   logic [2:0]    bit_idx;
   logic [2:0]    byte_idx;
   logic [7:0]    shreg;
   logic [7:0]    ld_byte;
   logic [15:0]   remaining;
   logic [23:0]   word_buf;
   logic          bit_end;
   logic          tx_done;
   logic          tx_idle;
   logic          ld;

   assign tx_idle = tx_state == TX_IDLE;
   assign bit_end = bit_cnt == CW'(CLK_PER_BIT - 1);
   assign tx_done = tx_state == TX_STOP && bit_end;

   // byte 0 goes straight from rd_data so the first start bit needs no extra handoff cycle
   always_comb begin
      ld      = state == CAPTURE || (state == SEND && tx_idle && !byte_idx[2]);
      ld_byte = state == CAPTURE ? rd_data[7:0] : word_buf[7:0];
`ifdef UART_DUMP_CHECKSUM_EN
      if (state == CHKSUM) begin
         ld      = tx_idle;
         ld_byte = checksum;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         tx_state  <= TX_IDLE;
         tx        <= 1'b1;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         byte_idx  <= '0;
         shreg     <= '0;
         remaining <= '0;
         word_buf  <= '0;
         rd_addr   <= '0;
         rd_en     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef UART_DUMP_CHECKSUM_EN
         checksum  <= '0;
`endif
      end else begin
         rd_en <= 1'b0;
         done  <= 1'b0;
         if (ld) begin
            tx       <= 1'b0;
            tx_state <= TX_START;
            bit_cnt  <= '0;
            shreg    <= ld_byte;
         end else if (!tx_idle) begin
            bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            if (bit_end)
               case (tx_state)
                  TX_START: begin
                     tx       <= shreg[0];
                     bit_idx  <= '0;
                     tx_state <= TX_DATA;
                  end
                  TX_DATA: begin
                     tx       <= bit_idx == 3'd7 ? 1'b1 : shreg[1];
                     tx_state <= bit_idx == 3'd7 ? TX_STOP : TX_DATA;
                     shreg    <= shreg >> 1;
                     bit_idx  <= bit_idx + 1'b1;
                  end
                  default: tx_state <= TX_IDLE;
               endcase
         end
`ifdef UART_DUMP_CHECKSUM_EN
         if (ld && state != CHKSUM)
            checksum <= checksum ^ ld_byte;
`endif
         case (state)
            IDLE:
               if (start) begin
                  remaining <= word_count;
                  rd_addr   <= '0;
`ifdef UART_DUMP_CHECKSUM_EN
                  checksum  <= '0;
`endif
                  rd_en     <= word_count != 16'd0;
                  busy      <= word_count != 16'd0;
                  done      <= word_count == 16'd0;
                  state     <= word_count == 16'd0 ? FINISH : READ;
               end
            READ: state <= CAPTURE;
            CAPTURE: begin
               word_buf <= rd_data[31:8];
               byte_idx <= '0;
               state    <= SEND;
            end
            SEND:
               if (tx_done) begin
                  byte_idx <= byte_idx + 1'b1;
                  if (byte_idx == 3'd3) begin
                     rd_addr   <= rd_addr + 32'd1;
                     remaining <= remaining - 16'd1;
                     if (remaining == 16'd1) begin
`ifdef UART_DUMP_CHECKSUM_EN
                        state <= CHKSUM;
`else
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`endif
                     end
                  end
               end else if (ld) begin
                  word_buf <= word_buf >> 8;
               end else if (tx_idle) begin
                  rd_en <= 1'b1;
                  state <= READ;
               end
`ifdef UART_DUMP_CHECKSUM_EN
            CHKSUM:
               if (tx_done) begin
                  state <= FINISH;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
`endif
            FINISH: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_mem_dumper.sv
// tb_uart_mem_dumper: cycle-level timing model of the dumper plus literal checks of decoded bytes and pulse timing.
module tb_uart_mem_dumper;
   localparam int CPB = 10;
   localparam int N = 8192;
`ifdef UART_DUMP_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] word_count = '0;
   logic [31:0] rd_addr;
   logic        rd_en;
   logic [31:0] rd_data = '0;
   logic        tx;
   logic        busy;
   logic        done;

   logic [31:0] mem [8];
   bit          exp_tx [N];
   bit          exp_busy [N];
   bit          exp_done [N];
   bit          exp_rden [N];
   int          exp_addr [N];
   int          cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   bit          chk_en = 1'b0;
   int          done_cnt = 0;
   int          done_cyc = -1;
   int          first_low = -1;
   logic [7:0]  rx_q [$];
   logic [31:0] addr_q [$];
   logic [7:0]  rx_b;
   logic [7:0]  bytes3 [13] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                                8'h01, 8'h00, 8'h00, 8'h00, 8'h2B};
   logic [7:0]  bytes1 [5] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h13};

   uart_mem_dumper #(.CLK_FREQ(1000), .BAUD_RATE(100)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
      .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
      .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[2:0]] : 32'hA5C3_3C5A;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         exp_tx[i] = 1'b1;
         exp_busy[i] = 1'b0;
         exp_done[i] = 1'b0;
         exp_rden[i] = 1'b0;
         exp_addr[i] = 0;
      end
   endtask

   task automatic frame(input int t, input logic [7:0] b);
      for (int k = 0; k < 10 * CPB; k++)
         exp_tx[t + k] = (k < CPB) ? 1'b0 : (k >= 9 * CPB) ? 1'b1 : b[k / CPB - 1];
   endtask

   // expected waveform of a whole dump whose start is sampled in cycle c
   task automatic build(input int c, input int n);
      int t;
      logic [7:0] x;
      logic [7:0] byt;
      logic [31:0] wd;
      x = '0;
      if (n == 0) begin
         exp_done[c + 1] = 1'b1;
         return;
      end
      t = c + 1;
      for (int w = 0; w < n; w++) begin
         exp_rden[t] = 1'b1;
         exp_addr[t] = w;
         t += 2;
         wd = mem[w];
         for (int b = 0; b < 4; b++) begin
            byt = wd[8 * b +: 8];
            x ^= byt;
            frame(t, byt);
            t += 10 * CPB;
            if (b < 3) t += 1;
         end
         if (w < n - 1) t += 1;
      end
      if (CK) begin
         t += 1;
         frame(t, x);
         t += 10 * CPB;
      end
      for (int k = c + 1; k < t; k++) exp_busy[k] = 1'b1;
      exp_done[t] = 1'b1;
   endtask

   task automatic go(input int n, output int c);
      @(negedge clk);
      start = 1'b1;
      word_count = 16'(n);
      c = cyc;
      done_cnt = 0;
      done_cyc = -1;
      first_low = -1;
      rx_q.delete();
      addr_q.delete();
      build(c, n);
      @(negedge clk);
      start = 1'b0;
   endtask

   always @(negedge clk)
      if (chk_en && cyc < N) begin
         chk("tx", tx, exp_tx[cyc]);
         chk("busy", busy, exp_busy[cyc]);
         chk("done", done, exp_done[cyc]);
         chk("rd_en", rd_en, exp_rden[cyc]);
         if (exp_rden[cyc]) chk("rd_addr", rd_addr, exp_addr[cyc]);
      end

   always @(negedge clk)
      if (rst_n) begin
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (rd_en) addr_q.push_back(rd_addr);
         if (!tx && first_low < 0) first_low = cyc;
      end

   initial forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
         repeat (CPB / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            rx_b[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         rx_q.push_back(rx_b);
      end
   end

   initial begin
      int c;
      int off;
      clear_model();
      for (int i = 0; i < 8; i++) mem[i] = 32'h0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      rst_n = 1'b1;
      chk_en = 1'b1;
      repeat (5) @(negedge clk);

      // asynchronous reset in the middle of the first start bit
      mem[0] = 32'h0000_0013;
      go(1, c);
      repeat (4) @(negedge clk);
      chk("pre_reset_tx", tx, 0);
      chk("pre_reset_busy", busy, 1);
      #2;
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_tx", tx, 1);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_done", done, 0);
      chk("async_rst_rd_en", rd_en, 0);
      repeat (3) @(negedge clk);
      clear_model();
      rst_n = 1'b1;
      chk_en = 1'b1;
      first_low = -1;
      done_cnt = 0;
      repeat (150) @(negedge clk);
      chk("post_reset_no_tx", first_low, -1);
      chk("post_reset_no_done", done_cnt, 0);

      // single word
      off = CK ? 507 : 406;
      go(1, c);
      while (cyc < c + off + 20) @(negedge clk);
      chk("w1_nbytes", rx_q.size(), CK ? 5 : 4);
      for (int i = 0; i < rx_q.size() && i < 5; i++) chk("w1_byte", rx_q[i], bytes1[i]);
      chk("w1_first_start", first_low - c, 3);
      chk("w1_done_at", done_cyc - c, off);
      chk("w1_done_cnt", done_cnt, 1);
      chk("w1_nreads", addr_q.size(), 1);
      if (addr_q.size() > 0) chk("w1_addr", addr_q[0], 0);

      // three words
      mem[0] = 32'h1234_5678;
      mem[1] = 32'hDEAD_BEEF;
      mem[2] = 32'h0000_0001;
      off = CK ? 1319 : 1218;
      go(3, c);
      while (cyc < c + off + 20) @(negedge clk);
      chk("w3_nbytes", rx_q.size(), CK ? 13 : 12);
      for (int i = 0; i < rx_q.size() && i < 13; i++) chk("w3_byte", rx_q[i], bytes3[i]);
      chk("w3_first_start", first_low - c, 3);
      chk("w3_done_at", done_cyc - c, off);
      chk("w3_done_cnt", done_cnt, 1);
      chk("w3_nreads", addr_q.size(), 3);
      for (int i = 0; i < addr_q.size() && i < 3; i++) chk("w3_addr", addr_q[i], i);

      // zero words
      go(0, c);
      repeat (10) @(negedge clk);
      chk("w0_done_at", done_cyc - c, 1);
      chk("w0_done_cnt", done_cnt, 1);
      chk("w0_nbytes", rx_q.size(), 0);
      chk("w0_nreads", addr_q.size(), 0);

      // start while busy, with word_count changed mid-dump
      go(3, c);
      repeat (300) @(negedge clk);
      start = 1'b1;
      word_count = 16'd5;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c + off + 20) @(negedge clk);
      chk("wb_nbytes", rx_q.size(), CK ? 13 : 12);
      for (int i = 0; i < rx_q.size() && i < 13; i++) chk("wb_byte", rx_q[i], bytes3[i]);
      chk("wb_done_at", done_cyc - c, off);
      chk("wb_done_cnt", done_cnt, 1);
      chk("wb_nreads", addr_q.size(), 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
